// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, counter constants and PC field helpers for the
//               gshare branch predictor / BTB.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int c_max_w     = 64;
    localparam int c_max_tag_w = 32;
    localparam int c_max_cnt_w = 4;

    // Sized for the widest legal configuration; narrower instances leave the
    // upper bits at zero.
    typedef struct packed {
        logic                   valid;
        logic [c_max_tag_w-1:0] tag;
        logic [c_max_w-1:0]     target;
        logic                   is_br;
    } btb_entry_t;

    typedef logic [c_max_cnt_w-1:0] cnt_t;

    function automatic cnt_t cnt_init(input int cnt_w);
        return cnt_t'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic cnt_t cnt_max(input int cnt_w);
        return cnt_t'((1 << cnt_w) - 1);
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c, input int cnt_w);
        return (c == cnt_max(cnt_w)) ? c : c + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction

    function automatic logic [31:0] bp_idx(input logic [c_max_w-1:0] pc, input int idx_w);
        logic [c_max_w-1:0] mask;
        mask = (c_max_w'(1) << idx_w) - c_max_w'(1);
        return 32'((pc >> 2) & mask);
    endfunction

    function automatic logic [c_max_tag_w-1:0] bp_tag(input logic [c_max_w-1:0] pc,
                                                      input int idx_w, input int tag_w);
        logic [c_max_w-1:0] mask;
        mask = (c_max_w'(1) << tag_w) - c_max_w'(1);
        return c_max_tag_w'((pc >> (idx_w + 2)) & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pht_counters.sv
`default_nettype none
// ============================================================================
// Module      : pht_counters
// Description : Pattern-history table of saturating counters with a
//               combinational read port and a synchronous train port.
// Revision    : 1.0 - initial release
// ============================================================================
module pht_counters
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(ENTRIES)-1:0]   i_rd_idx,
    output logic [CNT_W-1:0]             o_rd_cnt,
    input  logic                         i_wr_en,
    input  logic [$clog2(ENTRIES)-1:0]   i_wr_idx,
    input  logic                         i_wr_taken
);

    logic [CNT_W-1:0] r_cnt [ENTRIES];
    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_next;

    assign o_rd_cnt = r_cnt[i_rd_idx];

    always_comb begin
        w_cur  = r_cnt[i_wr_idx];
        w_next = i_wr_taken ? CNT_W'(sat_inc(cnt_t'(w_cur), CNT_W))
                            : CNT_W'(sat_dec(cnt_t'(w_cur)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_W'(cnt_init(CNT_W));
            end
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_btb.sv
`default_nettype none
// ============================================================================
// Module      : gshare_btb
// Description : Direct-mapped tagged BTB plus gshare PHT with a speculative
//               global history register restored on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_btb
    import bp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 6
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [WIDTH-1:0]                      pc_i,
    input  logic                                  stall_i,
    output logic                                  pred_hit_o,
    output logic                                  pred_taken_o,
    output logic [WIDTH-1:0]                      pred_target_o,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0]  pred_ghr_o,
    input  logic                                  upd_valid_i,
    input  logic [WIDTH-1:0]                      upd_pc_i,
    input  logic                                  upd_is_br_i,
    input  logic                                  upd_taken_i,
    input  logic [WIDTH-1:0]                      upd_target_i,
    input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0]  upd_ghr_i,
    input  logic                                  upd_mispredict_i
);

    localparam int c_idx_w = $clog2(ENTRIES);

    btb_entry_t r_btb [ENTRIES];

    logic [c_idx_w-1:0]     w_rd_idx;
    logic [c_max_tag_w-1:0] w_rd_tag;
    btb_entry_t             w_rd_entry;
    logic [CNT_W-1:0]       w_rd_cnt;
    logic                   w_hit;
    logic                   w_taken;

    logic [c_idx_w-1:0]     w_up_idx;
    logic [c_max_tag_w-1:0] w_up_tag;
    btb_entry_t             w_up_entry;
    logic [c_max_w-1:0]     w_up_target;
    logic                   w_up_hit;
    logic                   w_btb_we;
    btb_entry_t             w_new_entry;

    logic [c_idx_w-1:0]     w_ghr_rd;
    logic [c_idx_w-1:0]     w_ghr_up;
    logic [c_idx_w-1:0]     w_pht_rd_idx;
    logic [c_idx_w-1:0]     w_pht_up_idx;

    // Lookup side
    assign w_rd_idx   = c_idx_w'(bp_idx(c_max_w'(pc_i), c_idx_w));
    assign w_rd_tag   = bp_tag(c_max_w'(pc_i), c_idx_w, TAG_W);
    assign w_rd_entry = r_btb[w_rd_idx];
    assign w_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
    assign w_taken    = w_hit && (!w_rd_entry.is_br || w_rd_cnt[CNT_W-1]);

    assign pred_hit_o    = w_hit;
    assign pred_taken_o  = w_taken;
    assign pred_target_o = w_taken ? WIDTH'(w_rd_entry.target) : '0;

    // Training side
    assign w_up_idx    = c_idx_w'(bp_idx(c_max_w'(upd_pc_i), c_idx_w));
    assign w_up_tag    = bp_tag(c_max_w'(upd_pc_i), c_idx_w, TAG_W);
    assign w_up_entry  = r_btb[w_up_idx];
    assign w_up_target = c_max_w'(upd_target_i);
    assign w_up_hit    = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    // Not-taken branches that miss never allocate; a hit with a stale target
    // is refreshed even when not taken.
    assign w_btb_we = upd_valid_i &&
                      (upd_taken_i || (w_up_hit && (w_up_entry.target != w_up_target)));

    assign w_new_entry = '{valid: 1'b1, tag: w_up_tag, target: w_up_target, is_br: upd_is_br_i};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (w_btb_we) begin
            r_btb[w_up_idx] <= w_new_entry;
        end
    end

    generate
        if (GHR_W > 0) begin : g_ghr
            logic [GHR_W-1:0] r_ghr;
            logic [GHR_W-1:0] w_ghr_next;

            // Mispredict restore outranks the speculative shift.
            always_comb begin
                w_ghr_next = r_ghr;
                if (upd_valid_i && upd_mispredict_i) begin
                    w_ghr_next = upd_is_br_i ? GHR_W'({upd_ghr_i, upd_taken_i}) : upd_ghr_i;
                end else if (w_hit && w_rd_entry.is_br && !stall_i) begin
                    w_ghr_next = GHR_W'({r_ghr, w_taken});
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_ghr <= '0;
                end else begin
                    r_ghr <= w_ghr_next;
                end
            end

            assign w_ghr_rd   = c_idx_w'(r_ghr);
            assign w_ghr_up   = c_idx_w'(upd_ghr_i);
            assign pred_ghr_o = r_ghr;
        end else begin : g_no_ghr
            assign w_ghr_rd   = '0;
            assign w_ghr_up   = '0;
            assign pred_ghr_o = '0;
        end
    endgenerate

    assign w_pht_rd_idx = w_rd_idx ^ w_ghr_rd;
    assign w_pht_up_idx = w_up_idx ^ w_ghr_up;

    pht_counters #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) u_pht (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .i_rd_idx   (w_pht_rd_idx),
        .o_rd_cnt   (w_rd_cnt),
        .i_wr_en    (upd_valid_i && upd_is_br_i),
        .i_wr_idx   (w_pht_up_idx),
        .i_wr_taken (upd_taken_i)
    );

    a_entries_pow2: assert property (@(posedge clk_i)
        (ENTRIES >= 4) && ((ENTRIES & (ENTRIES - 1)) == 0));
    a_ghr_w: assert property (@(posedge clk_i) (GHR_W >= 0) && (GHR_W <= c_idx_w));
    a_widths: assert property (@(posedge clk_i)
        (WIDTH <= c_max_w) && (TAG_W <= c_max_tag_w) && (CNT_W >= 1) && (CNT_W <= c_max_cnt_w));
    a_upd_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        upd_valid_i |-> (upd_pc_i[1:0] == 2'b00));

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_btb
// Description : Directed table-driven bench for gshare_btb (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_btb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [5:0]  pred_ghr_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_is_br_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [5:0]  upd_ghr_i;
    logic        upd_mispredict_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    gshare_btb dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pc_i             (pc_i),
        .stall_i          (stall_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .pred_ghr_o       (pred_ghr_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_is_br_i      (upd_is_br_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_ghr_i        (upd_ghr_i),
        .upd_mispredict_i (upd_mispredict_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        uv;
        logic [31:0] upc;
        logic        ubr;
        logic        utk;
        logic [31:0] utgt;
        logic [5:0]  ughr;
        logic        umis;
        logic        ehit;
        logic        etk;
        logic [31:0] etgt;
        logic [5:0]  eghr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic [31:0] pc, logic stall, logic uv, logic [31:0] upc,
                                 logic ubr, logic utk, logic [31:0] utgt, logic [5:0] ughr,
                                 logic umis, logic ehit, logic etk, logic [31:0] etgt,
                                 logic [5:0] eghr);
        vec_t t;
        t.pc = pc; t.stall = stall; t.uv = uv; t.upc = upc; t.ubr = ubr; t.utk = utk;
        t.utgt = utgt; t.ughr = ughr; t.umis = umis;
        t.ehit = ehit; t.etk = etk; t.etgt = etgt; t.eghr = eghr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check lookup outputs mid-cycle, then let the edge commit.
    task automatic apply(input vec_t t, input string nm);
        pc_i             = t.pc;
        stall_i          = t.stall;
        upd_valid_i      = t.uv;
        upd_pc_i         = t.upc;
        upd_is_br_i      = t.ubr;
        upd_taken_i      = t.utk;
        upd_target_i     = t.utgt;
        upd_ghr_i        = t.ughr;
        upd_mispredict_i = t.umis;
        @(negedge clk_i);
        chk({nm, " hit"},    32'(pred_hit_o),   32'(t.ehit));
        chk({nm, " taken"},  32'(pred_taken_o), 32'(t.etk));
        chk({nm, " target"}, pred_target_o,     t.etgt);
        chk({nm, " ghr"},    32'(pred_ghr_o),   32'(t.eghr));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; pc_i = '0; stall_i = 1'b1; upd_valid_i = 1'b0; upd_pc_i = '0;
        upd_is_br_i = 1'b0; upd_taken_i = 1'b0; upd_target_i = '0; upd_ghr_i = '0;
        upd_mispredict_i = 1'b0;

        //           pc        st uv upc       br tk tgt       ughr       mis  hit tk etgt     eghr
        vecs.push_back(mkv(32'h100,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 1, 32'h200, 6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h100,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 1, 32'h200, 6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 1, 32'h200, 6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 1, 32'h200, 6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 0, 32'h200, 6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 1, 32'h100, 1, 0, 32'h200, 6'd0,      0,   1, 1, 32'h200, 6'd0));
        vecs.push_back(mkv(32'h100,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h4100, 1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h300,  1, 1, 32'h300, 0, 1, 32'h80,  6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h300,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h80,  6'd0));
        vecs.push_back(mkv(32'h100,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h104, 1, 0, 32'h400, 6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h104, 1, 1, 32'h400, 6'd0,      0,   0, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h104, 1, 0, 32'h500, 6'd0,      0,   1, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h104, 1, 1, 32'h500, 6'd0,      0,   1, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h104, 1, 1, 32'h500, 6'd0,      0,   1, 0, 32'h0,   6'd0));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h500, 6'd0));
        vecs.push_back(mkv(32'h300,  0, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h80,  6'd0));
        vecs.push_back(mkv(32'h300,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h80,  6'd0));
        // Global history: speculative shifts, gshare indexing, restore priority.
        vecs.push_back(mkv(32'h104,  0, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 1, 32'h500, 6'd0));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'd1));
        vecs.push_back(mkv(32'h104,  0, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'd1));
        vecs.push_back(mkv(32'h104,  0, 1, 32'h10C, 1, 1, 32'h600, 6'b101010, 1,   1, 0, 32'h0,   6'd2));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'b010101));
        vecs.push_back(mkv(32'h104,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'b010101));
        vecs.push_back(mkv(32'h104,  1, 1, 32'h300, 0, 1, 32'h80,  6'b110011, 1,   1, 0, 32'h0,   6'b010101));
        vecs.push_back(mkv(32'h10C,  1, 0, 32'h0,   0, 0, 32'h0,   6'd0,      0,   1, 0, 32'h0,   6'b110011));

        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Reset mid-operation with a concurrent update: everything is dropped.
        rst_ni = 1'b0; pc_i = 32'h104; stall_i = 1'b0;
        upd_valid_i = 1'b1; upd_pc_i = 32'h200; upd_is_br_i = 1'b1; upd_taken_i = 1'b1;
        upd_target_i = 32'h900; upd_ghr_i = 6'b111111; upd_mispredict_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        apply(mkv(32'h104, 1, 0, 32'h0, 0, 0, 32'h0, 6'd0, 0, 0, 0, 32'h0, 6'd0), "rst_104");
        apply(mkv(32'h300, 1, 0, 32'h0, 0, 0, 32'h0, 6'd0, 0, 0, 0, 32'h0, 6'd0), "rst_300");
        apply(mkv(32'h10C, 1, 0, 32'h0, 0, 0, 32'h0, 6'd0, 0, 0, 0, 32'h0, 6'd0), "rst_10c");
        apply(mkv(32'h200, 1, 0, 32'h0, 0, 0, 32'h0, 6'd0, 0, 0, 0, 32'h0, 6'd0), "rst_200");
        // Counters restart at weakly not-taken: one taken then one not-taken predicts not-taken.
        apply(mkv(32'h104, 1, 1, 32'h104, 1, 1, 32'h500, 6'd0, 0, 0, 0, 32'h0, 6'd0), "init_t");
        apply(mkv(32'h104, 1, 1, 32'h104, 1, 0, 32'h500, 6'd0, 0, 1, 1, 32'h500, 6'd0), "init_nt");
        apply(mkv(32'h104, 1, 0, 32'h0,   0, 0, 32'h0,   6'd0, 0, 1, 0, 32'h0,   6'd0), "init_chk");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_btb.md
Name: gshare_btb

Overview:
- Parametrised successor to the fetch-stage BTB/2-bit predictor pair.
- Combines a tagged, direct-mapped BTB with a gshare pattern-history table of configurable-width saturating counters, indexed by PC XOR a global history register (GHR).
- Sits beside the PC register: lookup is combinational on the fetch PC, and training is synchronous from the EX-stage branch resolution.
- Also holds the speculative GHR and restores it on mispredict.

Parameters:
- Width, 32: PC/target width.
- Entries, 64: BTB and PHT depth; must be a power of 2, at least 4.
- TagW, 8: stored tag bits.
- CntW, 2: saturating counter width, 1..4.
- GhrW, 6: history length, 0..log2(Entries). 0 gives a pure bimodal predictor.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- pc_i  in  Width  fetch PC to look up.
- stall_i  in  1  fetch stalled; suppresses the speculative GHR shift.
- pred_hit_o  out  1  BTB tag match on pc_i.
- pred_taken_o  out  1  predicted redirect.
- pred_target_o  out  Width  predicted target; 0 when pred_taken_o=0.
- pred_ghr_o  out  max(GhrW,1)  GHR value used for this lookup; carried down the pipeline.
- upd_valid_i  in  1  resolution from EX.
- upd_pc_i  in  Width  PC of the resolved instruction.
- upd_is_br_i  in  1  1 = conditional branch, 0 = JAL/JALR.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  Width  actual target.
- upd_ghr_i  in  max(GhrW,1)  pred_ghr_o snapshot carried with the instruction.
- upd_mispredict_i  in  1  direction or target mismatch.

Behaviour:
- Fields:
  - IdxW = log2(Entries).
  - idx = pc[IdxW+1:2]; tag = pc[IdxW+TagW+1:IdxW+2].
  - BTB entry = {valid, tag, target, is_br}.
  - PHT index = idx XOR zero-extended GHR, using the lookup GHR for prediction and upd_ghr_i for training.
- Lookup (combinational, zero latency):
  - hit = valid & (tag match).
  - taken = hit & (!is_br | counter MSB).
  - Jumps that hit are always predicted taken.
- Read-during-write: a lookup in the same cycle as an update to the same entry sees the old contents. The new contents are visible the next cycle.
- Training on upd_valid_i=1, at the clock edge:
  - Conditional branch: its PHT counter increments on taken, saturating at 2^CntW-1, and decrements on not-taken, saturating at 0.
  - BTB write {1, tag, upd_target_i, upd_is_br_i} happens when upd_taken_i=1 (allocate or overwrite, no replacement policy), or when the entry already hits with a different target.
  - A not-taken branch that misses the BTB trains the PHT only and does not allocate.
- GHR (shift left, new bit in the LSB):
  - Speculative shift in of pred_taken_o when pred_hit_o & is_br & !stall_i.
  - On upd_valid_i & upd_mispredict_i & upd_is_br_i: GHR <= {upd_ghr_i[GhrW-2:0], upd_taken_i}.
  - On a mispredicted jump: GHR <= upd_ghr_i.
  - Restore has priority over a simultaneous speculative shift.
  - GhrW=0: the GHR is absent and pred_ghr_o is tied to 0.
- Reset (rst_ni=0 at an edge):
  - All valid bits clear.
  - All counters set to 2^(CntW-1)-1 (weakly not-taken; 01 for CntW=2).
  - GHR = 0.
  - Outputs therefore read hit=0, taken=0, target=0, ghr=0 from the first cycle after reset.
  - Reset overrides any concurrent update.
  - Reset mid-operation discards all learned state.
- Storage: flops (no RAM macro), so per-entry reset is legal.
- Assertions: Entries is a power of 2; GhrW <= IdxW; upd_pc_i is word-aligned when upd_valid_i=1.

Decomposition:
- Package bp_pkg:
  - btb_entry_t struct.
  - Counter init/max constants as functions of CntW.
  - Functions bp_idx(pc) and bp_tag(pc).
  - sat_inc/sat_dec helpers.
- One sub-module, pht_counters: Entries x CntW saturating counters with combinational read port, synchronous train port and reset init.
- BTB array and GHR stay in the top.

Test Plan (defaults):
- Reset, then pc_i=0x0000_0100 -> hit=0, taken=0, target=0, ghr=0.
- Update pc=0x100, is_br=1, taken=1, target=0x200, ghr=0, mispredict=0; next cycle lookup 0x100 -> hit=1, counter 01->10, taken=1, target=0x200.
- Three more taken updates (counter saturates at 11), then one not-taken -> taken=1 (10); a second not-taken -> taken=0 (01), hit still 1.
- Lookup 0x0000_4100 (same idx 0, tag 0x41 vs 0x01) -> hit=0, taken=0. Then a JAL update at pc=0x300, target 0x80 -> lookup 0x300 gives taken=1, target 0x80 regardless of counter.
- Hitting branch lookup with stall_i=0 shifts the GHR. In the same cycle, a mispredict update with upd_ghr_i=6'b101010, taken=1 -> GHR=6'b010101 (restore wins). With stall_i=1 and no update -> GHR unchanged.
- Train several entries, hold rst_ni=0 for one cycle while upd_valid_i=1 -> all lookups hit=0, GHR=0, and the concurrent update is lost.
